exec_pipe: RTL and testbench
============================

Name: exec_pipe

Overview:
- Parametrised, registered successor to the single-cycle MIPS execute unit. Sits between the ID/EX boundary and the MEM stage.
- Computes the ALU result, zero and signed-overflow flags, branch target and destination register.
- Adds a valid/ready handshake, flush, and an iterative multi-cycle multiplier that stalls upstream while busy.

Parameters:
- WIDTH, 32, datapath width for busA/busB/PC/ALUout/Target; must be ≥16.
- RADDR_W, 5, register-address width; instruction fields are sliced at MIPS positions.
- MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL opcode returns 0 in one cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill in-flight op and output register.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  exec can accept this cycle.
- PC  in  WIDTH  PC+4 of the instruction.
- busA  in  WIDTH  rs operand.
- busB  in  WIDTH  rt operand.
- instr  in  32  raw instruction.
- ALUop  in  4  operation select.
- ExtOp  in  1  1 = sign-extend imm16, 0 = zero-extend.
- ALUSrc  in  1  1 = operand B is the extended immediate.
- RegDst  in  1  1 = instr[15:11], 0 = instr[20:16].
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- ALUout  out  WIDTH  result.
- zero  out  1  ALUout == 0.
- ovf  out  1  signed overflow on ADD/SUB, else 0.
- Target  out  WIDTH  PC + (signext(imm16) << 2).
- Regout  out  RADDR_W  destination register.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0; ALUout, Target, Regout, zero and ovf all 0; FSM→IDLE. Mid-multiply reset aborts the multiply with no output.
- ALUop encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed), 0101 SLTU, 0110 XOR, 0111 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA. Shift amount is instr[10:6]; the shifted operand is B.
  - 1011 MUL: low WIDTH bits of the product.
  - All others: ALUout=0.
- Operand B = ALUSrc ? ext(imm16) : busB. ext(imm16) uses ExtOp; the result is WIDTH bits.
- Target always uses sign extension, independent of ExtOp. The sum wraps modulo 2^WIDTH.
- ovf = ADD: sign(A)==sign(B) and sign(result)≠sign(A). SUB: sign(A)≠sign(B) and sign(result)≠sign(A).
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - While out_valid && !out_ready, all outputs hold stable.
- Single-cycle ops: accepted at edge N, so out_valid=1 after edge N with the result registered (latency 1). Back-to-back accept is allowed when out_ready=1.
- FSM states IDLE, MUL, DONE:
  - IDLE→MUL on accept with ALUop=MUL and MUL_EN=1. A, B, Target and Regout are latched, and the counter is loaded with WIDTH.
  - MUL performs one shift-add step per cycle and decrements the counter. At counter==1 it moves to DONE.
  - DONE loads the output register and sets out_valid, then →IDLE. Total latency is WIDTH+1 cycles from accept.
  - in_ready=0 in MUL and DONE.
- Flush is synchronous and takes priority below reset. It clears out_valid, forces FSM→IDLE, and holds in_ready=0 that cycle. in_valid during flush is ignored.
- If out_ready and a new accept occur in the same cycle, the old result retires and the new result loads (no bubble).

Decomposition:
- Package exec_pkg holds the ALUop localparams (ALU_ADD … ALU_MUL), the FSM state encodings, and the instruction field positions (RS/RT/RD/SHAMT/IMM).
- One sub-module, iter_mul: start/busy/done handshake, WIDTH parameter, shift-add core.
- The ALU and extend/target logic stay combinational inside exec_pipe.

Test Plan:
- ADD A=2, B=8, RegDst=0, instr=0x00222028, out_ready=1 → next cycle ALUout=10, zero=0, ovf=0, Regout=2. Same inputs with RegDst=1 → Regout=4.
- SUB A=B=0x7 → ALUout=0, zero=1. ADD A=0x7FFFFFFF, B=1 → ALUout=0x80000000, ovf=1.
- ALUSrc=1, ExtOp=1, imm=0xFFFC, PC=0x100, ALUop=ADD, A=0x10 → ALUout=0xC, Target=0xF0. ExtOp=0 → ALUout=0x1000C, Target still 0xF0.
- MUL A=123, B=−2 → in_ready low for 33 cycles, out_valid on cycle 33, ALUout=0xFFFFFF0A. Assert flush at cycle 10 → out_valid never rises, in_ready=1 the cycle after.
- Backpressure: ADD result with out_ready=0 for 3 cycles → outputs stable, in_ready=0. Raise out_ready together with a new OR op → OR result the next cycle, no bubble.
- rst_n=0 mid-MUL → all outputs 0, out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states and
// MIPS instruction field positions.
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } exec_state_e;

    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = 16;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b,
// one partial-product step per cycle over WIDTH cycles.
module iter_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CntW'(WIDTH);
        end else if (busy) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // done flags the final step: product is valid on the following cycle
    assign busy    = (cnt_q != '0);
    assign done    = (cnt_q == CntW'(1));
    assign product = acc_q;

endmodule

// File: rtl/exec_pipe.sv
// Registered MIPS execute stage: ALU, flags, branch target and destination
// register, with valid/ready handshake, flush and an iterative multiplier.
module exec_pipe
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   PC,
    input  logic [WIDTH-1:0]   busA,
    input  logic [WIDTH-1:0]   busB,
    input  logic [31:0]        instr,
    input  logic [3:0]         ALUop,
    input  logic               ExtOp,
    input  logic               ALUSrc,
    input  logic               RegDst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUout,
    output logic               zero,
    output logic               ovf,
    output logic [WIDTH-1:0]   Target,
    output logic [RADDR_W-1:0] Regout
);

    exec_state_e state_q, state_d;

    logic [IMM_W-1:0]   imm16;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   imm_sext, imm_zext, opb;
    logic [WIDTH-1:0]   sum, diff, target_c;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               lt_s, lt_u;
    logic [RADDR_W-1:0] dst_c;

    logic               accept, use_mul, mul_start;
    logic               mul_busy, mul_done;
    logic [WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]   tgt_hold_q;
    logic [RADDR_W-1:0] dst_hold_q;

    // opcode and rs are decoded upstream
    logic unused_instr;
    assign unused_instr = ^instr[31:RS_LSB];

    assign imm16    = instr[IMM_LSB +: IMM_W];
    assign shamt    = instr[SHAMT_LSB +: SHAMT_W];
    assign imm_sext = WIDTH'($signed(imm16));
    assign imm_zext = WIDTH'(imm16);
    assign opb      = ALUSrc ? (ExtOp ? imm_sext : imm_zext) : busB;
    assign target_c = PC + (imm_sext << 2);
    assign dst_c    = RegDst ? instr[RD_LSB +: RADDR_W] : instr[RT_LSB +: RADDR_W];

    assign sum  = busA + opb;
    assign diff = busA - opb;
    assign lt_s = ($signed(busA) < $signed(opb));
    assign lt_u = (busA < opb);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUop)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (busA[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != busA[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (busA[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != busA[WIDTH-1]);
            end
            ALU_AND:  alu_res = busA & opb;
            ALU_OR:   alu_res = busA | opb;
            ALU_SLT:  alu_res = WIDTH'(lt_s);
            ALU_SLTU: alu_res = WIDTH'(lt_u);
            ALU_XOR:  alu_res = busA ^ opb;
            ALU_NOR:  alu_res = ~(busA | opb);
            ALU_SLL:  alu_res = opb << shamt;
            ALU_SRL:  alu_res = opb >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(opb) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    assign in_ready  = (state_q == StIdle) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign use_mul   = (MUL_EN != 0) && (ALUop == ALU_MUL);
    assign mul_start = accept && use_mul;

    iter_mul #(
        .WIDTH (WIDTH)
    ) u_iter_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .start   (mul_start),
        .a       (busA),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (mul_start) state_d = StMul;
            StMul: begin
                if (mul_done) begin
                    state_d = StDone;
                end else if (!mul_busy) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ALUout     <= '0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            Target     <= '0;
            Regout     <= '0;
            tgt_hold_q <= '0;
            dst_hold_q <= '0;
        end else begin
            if (mul_start) begin
                tgt_hold_q <= target_c;
                dst_hold_q <= dst_c;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept && !use_mul) begin
                out_valid <= 1'b1;
                ALUout    <= alu_res;
                zero      <= (alu_res == '0);
                ovf       <= alu_ovf;
                Target    <= target_c;
                Regout    <= dst_c;
            end else if (state_q == StDone) begin
                out_valid <= 1'b1;
                ALUout    <= mul_product;
                zero      <= (mul_product == '0);
                ovf       <= 1'b0;
                Target    <= tgt_hold_q;
                Regout    <= dst_hold_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_pipe.sv
// Bench for exec_pipe: constant vector table, randomized traffic against a
// behavioural model, and hand-written multiply/flush/backpressure/reset cases.
module tb_exec_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] PC, busA, busB, instr, ALUout, Target;
    logic [3:0]  ALUop;
    logic        ExtOp, ALUSrc, RegDst, zero, ovf;
    logic [4:0]  Regout;

    int n_checks = 0;
    int n_pass   = 0;

    exec_pipe #(
        .WIDTH   (32),
        .RADDR_W (5),
        .MUL_EN  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .PC        (PC),
        .busA      (busA),
        .busB      (busB),
        .instr     (instr),
        .ALUop     (ALUop),
        .ExtOp     (ExtOp),
        .ALUSrc    (ALUSrc),
        .RegDst    (RegDst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .zero      (zero),
        .ovf       (ovf),
        .Target    (Target),
        .Regout    (Regout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, ins, pc;
        logic        ext, src, dst;
        logic [31:0] e_alu;
        logic        e_zero, e_ovf;
        logic [31:0] e_tgt;
        logic [4:0]  e_reg;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic        ovf;
        logic [31:0] tgt;
        logic [4:0]  rd;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, b, ins, pc,
                         input logic ext, src, dst);
        ALUop = op; busA = a; busB = b; instr = ins; PC = pc;
        ExtOp = ext; ALUSrc = src; RegDst = dst;
    endtask

    // Reference: arithmetic straight from the opcode definitions
    function automatic res_t ref_model(input logic [3:0] op, input logic [31:0] a, b, ins, pc,
                                       input logic ext, src, dst);
        logic [31:0] imm_s, imm_z, opb;
        longint      wide;
        int          sh;
        res_t        r;
        imm_z = {16'h0000, ins[15:0]};
        imm_s = {{16{ins[15]}}, ins[15:0]};
        opb   = src ? (ext ? imm_s : imm_z) : b;
        sh    = int'(ins[10:6]);
        r.alu = '0;
        r.ovf = 1'b0;
        case (op)
            4'd0: begin
                r.alu = a + opb;
                wide  = longint'($signed(a)) + longint'($signed(opb));
                r.ovf = (wide != longint'($signed(r.alu)));
            end
            4'd1: begin
                r.alu = a - opb;
                wide  = longint'($signed(a)) - longint'($signed(opb));
                r.ovf = (wide != longint'($signed(r.alu)));
            end
            4'd2:  r.alu = a & opb;
            4'd3:  r.alu = a | opb;
            4'd4:  r.alu = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            4'd5:  r.alu = (a < opb) ? 32'd1 : 32'd0;
            4'd6:  r.alu = a ^ opb;
            4'd7:  r.alu = ~(a | opb);
            4'd8:  r.alu = opb << sh;
            4'd9:  r.alu = opb >> sh;
            4'd10: r.alu = $signed(opb) >>> sh;
            4'd11: r.alu = 32'(longint'(a) * longint'(opb));
            default: r.alu = '0;
        endcase
        r.zero = (r.alu == 32'd0);
        r.tgt  = pc + imm_s * 32'd4;
        r.rd   = dst ? ins[15:11] : ins[20:16];
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        res_t m;
        logic mv;
        int   low, k, rises;

        vecs[0]  = '{4'h0, 32'd2, 32'd8, 32'h00222028, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'd10, 1'b0, 1'b0, 32'h80A0, 5'd2};
        vecs[1]  = '{4'h0, 32'd2, 32'd8, 32'h00222028, 32'h0, 1'b0, 1'b0, 1'b1,
                     32'd10, 1'b0, 1'b0, 32'h80A0, 5'd4};
        vecs[2]  = '{4'h1, 32'd7, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'd0, 1'b1, 1'b0, 32'h0, 5'd0};
        vecs[3]  = '{4'h0, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h80000000, 1'b0, 1'b1, 32'h0, 5'd0};
        vecs[4]  = '{4'h0, 32'h10, 32'h0, 32'h0000FFFC, 32'h100, 1'b1, 1'b1, 1'b0,
                     32'hC, 1'b0, 1'b0, 32'hF0, 5'd0};
        vecs[5]  = '{4'h0, 32'h10, 32'h0, 32'h0000FFFC, 32'h100, 1'b0, 1'b1, 1'b0,
                     32'h1000C, 1'b0, 1'b0, 32'hF0, 5'd0};
        vecs[6]  = '{4'h1, 32'h80000000, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h7FFFFFFF, 1'b0, 1'b1, 32'h0, 5'd0};
        vecs[7]  = '{4'h4, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'd1, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[8]  = '{4'h5, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'd0, 1'b1, 1'b0, 32'h0, 5'd0};
        vecs[9]  = '{4'hA, 32'h0, 32'h80000000, 32'h00000100, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'hF8000000, 1'b0, 1'b0, 32'h400, 5'd0};
        vecs[10] = '{4'h7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[11] = '{4'hF, 32'd5, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'd0, 1'b1, 1'b0, 32'h0, 5'd0};
        vecs[12] = '{4'h8, 32'h0, 32'd1, 32'h000007C0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h80000000, 1'b0, 1'b0, 32'h1F00, 5'd0};

        // Reset state
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_aluout", ALUout, 32'd0);
        chk("reset_target", Target, 32'd0);
        chk("reset_regout", 32'(Regout), 32'd0);
        chk("reset_flags", {30'd0, zero, ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Vector table, back-to-back
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ins, vecs[i].pc,
                  vecs[i].ext, vecs[i].src, vecs[i].dst);
            in_valid = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_alu", i), ALUout, vecs[i].e_alu);
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].e_zero));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_tgt", i), Target, vecs[i].e_tgt);
            chk($sformatf("vec%0d_reg", i), 32'(Regout), 32'(vecs[i].e_reg));
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Randomized single-cycle traffic with random backpressure
        mv = 1'b0;
        m  = '0;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd11) op = op + 4'd1;
            drive(op, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(!mv || out_ready));
            if (in_valid && (!mv || out_ready)) begin
                m  = ref_model(ALUop, busA, busB, instr, PC, ExtOp, ALUSrc, RegDst);
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rnd_out_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                chk("rnd_alu", ALUout, m.alu);
                chk("rnd_flags", {30'd0, zero, ovf}, {30'd0, m.zero, m.ovf});
                chk("rnd_tgt", Target, m.tgt);
                chk("rnd_reg", 32'(Regout), 32'(m.rd));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Multiply latency; inputs scrambled after accept to prove latching
        drive(4'hB, 32'd123, 32'hFFFFFFFE, 32'h00432000, 32'h40, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("mul_accept_ready", 32'(in_ready), 32'd1);
        step();
        drive(4'h0, 32'h55, 32'h66, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b1, 1'b0);
        out_ready = 1'b0;
        low = 0;
        k   = 0;
        while (!out_valid && k < 60) begin
            if (!in_ready) low++;
            step();
            k++;
        end
        chk("mul_latency", 32'(k), 32'd33);
        chk("mul_ready_low", 32'(low), 32'd33);
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_alu", ALUout, 32'hFFFFFF0A);
        chk("mul_tgt", Target, 32'h8040);
        chk("mul_reg", 32'(Regout), 32'd4);
        chk("mul_flags", {30'd0, zero, ovf}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mul_drain", 32'(out_valid), 32'd0);

        // Flush mid-multiply
        drive(4'hB, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush    = 1'b1;
        in_valid = 1'b1;
        drive(4'h0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_after_ready", 32'(in_ready), 32'd1);
        chk("flush_after_valid", 32'(out_valid), 32'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) rises++;
        end
        chk("flush_no_result", 32'(rises), 32'd0);

        // Backpressure then retire-and-load in the same cycle
        drive(4'h0, 32'd100, 32'd23, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_alu", ALUout, 32'd123);
        drive(4'h3, 32'hF0, 32'h0F, 32'h00430800, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_alu", ALUout, 32'd123);
            chk("bp_hold_tgt", Target, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_alu", ALUout, 32'hFF);
        chk("bp_next_tgt", Target, 32'h2000);
        chk("bp_next_reg", 32'(Regout), 32'd3);
        in_valid = 1'b0;
        step();

        // Reset mid-multiply
        drive(4'hB, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_alu", ALUout, 32'd0);
        chk("rst_mid_tgt", Target, 32'd0);
        chk("rst_mid_reg", 32'(Regout), 32'd0);
        chk("rst_mid_flags", {30'd0, zero, ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) rises++;
        end
        chk("rst_mid_no_result", 32'(rises), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
